// File: rtl/getbits_param_if.sv
// rtl/getbits_param_if.sv - bus between input FIFO, getbits reader and VLD
// slave is the reader side, master the FIFO/VLD side.
interface getbits_param_if #(
   parameter int IN_W  = 64,
   parameter int GB_W  = 24,
   parameter int ADV_W = 5,
   parameter int CNT_W = 32
);
   logic             clk_en;
   logic [IN_W-1:0]  vid_in;
   logic             vid_in_rd_en;
   logic             vid_in_rd_valid;
   logic [ADV_W-1:0] advance;
   logic             align;
   logic             seek_sc;
   logic             flush;
   logic             wait_state;
   logic             stall;
   logic [GB_W-1:0]  getbits;
   logic             signbit;
   logic             getbits_valid;
   logic             sc_found;
   logic [CNT_W-1:0] bit_count;
   logic             vld_en;

   modport slave (
      input  clk_en, vid_in, vid_in_rd_valid, advance, align, seek_sc, flush, wait_state, stall,
      output vid_in_rd_en, getbits, signbit, getbits_valid, sc_found, bit_count, vld_en
   );

   modport master (
      output clk_en, vid_in, vid_in_rd_valid, advance, align, seek_sc, flush, wait_state, stall,
      input  vid_in_rd_en, getbits, signbit, getbits_valid, sc_found, bit_count, vld_en
   );
endinterface

// File: rtl/getbits_param.sv
// rtl/getbits_param.sv - bitstream reader with cursor window, start-code seek and flush
// Cursor counts bits from the MSB of a two-word buffer; refills shift one word in from the bottom.
module getbits_param #(
   parameter int IN_W  = 64,
   parameter int GB_W  = 24,
   parameter int ADV_W = 5,
   parameter int CNT_W = 32
) (
   input  logic           clk,
   input  logic           rst,
   getbits_param_if.slave bus
);
   localparam int BUF_W = 2 * IN_W;
   localparam int CUR_W = $clog2(BUF_W + 1);
   localparam int WIN_W = GB_W + 1;
   localparam logic [CUR_W-1:0] IN_W_C  = CUR_W'(IN_W);
   localparam logic [CUR_W-1:0] EMPTY_C = CUR_W'(BUF_W);
   localparam logic [CUR_W-1:0] GB_W_C  = CUR_W'(GB_W);
   localparam logic [CUR_W-1:0] BYTE_C  = CUR_W'(8);
   localparam logic [CUR_W-1:0] LSB3_C  = CUR_W'(7);

   typedef enum logic [1:0] {FILL = 2'd0, READY = 2'd1, SEEK = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [BUF_W-1:0] dta_q, dta_d;
   logic [CUR_W-1:0] cursor_q, cursor_d;
   logic             rd_pending_q, rd_pending_d;
   logic             discard_q, discard_d;
   logic             seek_pending_q, seek_pending_d;
   logic             rd_en_q, rd_en_d;
   logic             sc_found_q, sc_found_d;
   logic             vld_en_q, vld_en_d;
   logic [GB_W-1:0]  getbits_q, getbits_d;
   logic             signbit_q, signbit_d;
   logic [CNT_W-1:0] bit_count_q, bit_count_d;

   logic [31:0]      adv_ext;
   logic [CUR_W-1:0] adv_sat;
   logic [BUF_W-1:0] shifted;
   logic [WIN_W-1:0] window;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= FILL;
         dta_q          <= '0;
         cursor_q       <= EMPTY_C;
         rd_pending_q   <= 1'b0;
         discard_q      <= 1'b0;
         seek_pending_q <= 1'b0;
         rd_en_q        <= 1'b0;
         sc_found_q     <= 1'b0;
         vld_en_q       <= 1'b1;
         getbits_q      <= '0;
         signbit_q      <= 1'b0;
         bit_count_q    <= '0;
      end else if (bus.clk_en) begin
         state_q        <= state_d;
         dta_q          <= dta_d;
         cursor_q       <= cursor_d;
         rd_pending_q   <= rd_pending_d;
         discard_q      <= discard_d;
         seek_pending_q <= seek_pending_d;
         rd_en_q        <= rd_en_d;
         sc_found_q     <= sc_found_d;
         vld_en_q       <= vld_en_d;
         getbits_q      <= getbits_d;
         signbit_q      <= signbit_d;
         bit_count_q    <= bit_count_d;
      end
   end

   always_comb begin : next_state
      state_d        = state_q;
      dta_d          = dta_q;
      cursor_d       = cursor_q;
      rd_pending_d   = rd_pending_q;
      discard_d      = discard_q;
      seek_pending_d = seek_pending_q;
      rd_en_d        = 1'b0;
      sc_found_d     = 1'b0;
      adv_ext        = 32'(bus.advance);
      adv_sat        = (adv_ext > 32'(GB_W)) ? GB_W_C : CUR_W'(adv_ext);

      if (bus.flush) begin
         dta_d          = '0;
         cursor_d       = EMPTY_C;
         seek_pending_d = 1'b0;
         state_d        = FILL;
         // an issued read still returns a word later; remember to drop it
         rd_pending_d   = rd_pending_q & ~bus.vid_in_rd_valid;
         discard_d      = rd_pending_d;
      end else begin
         case (state_q)
            FILL: begin
               if (bus.vid_in_rd_valid) begin
                  if (!discard_q) begin
                     dta_d    = {dta_q[IN_W-1:0], bus.vid_in};
                     cursor_d = cursor_q - IN_W_C;
                  end
                  rd_pending_d = 1'b0;
                  discard_d    = 1'b0;
               end else if (!rd_pending_q) begin
                  rd_en_d      = 1'b1;
                  rd_pending_d = 1'b1;
               end
            end
            READY: begin
               if (bus.seek_sc) begin
                  cursor_d       = (cursor_q + LSB3_C) & ~LSB3_C;
                  seek_pending_d = 1'b1;
                  state_d        = SEEK;
               end else if (bus.align) begin
                  cursor_d = (cursor_q & ~LSB3_C) + BYTE_C;
               end else begin
                  cursor_d = cursor_q + adv_sat;
               end
            end
            SEEK: begin
               if (getbits_q[GB_W-1 -: 24] == 24'h000001) begin
                  sc_found_d     = 1'b1;
                  seek_pending_d = 1'b0;
                  state_d        = READY;
               end else begin
                  cursor_d = cursor_q + BYTE_C;
               end
            end
            default: state_d = FILL;
         endcase

         if (cursor_d >= IN_W_C)
            state_d = FILL;
         else if (state_q == FILL)
            state_d = seek_pending_q ? SEEK : READY;
      end

      if (bus.flush)
         bit_count_d = '0;
      else if (state_q != FILL)
         bit_count_d = bit_count_q + CNT_W'(cursor_d - cursor_q);
      else
         bit_count_d = bit_count_q;

      shifted                = dta_d << cursor_d;
      window                 = WIN_W'(shifted >> (BUF_W - WIN_W));
      {getbits_d, signbit_d} = window;

      // VLD evaluates on one cycle, getbits moves on the next
      vld_en_d = (state_d == READY) && !bus.stall && (!vld_en_q || !bus.wait_state);
   end

   always_comb begin : outputs
      bus.getbits_valid = (state_q == READY);
      bus.vid_in_rd_en  = rd_en_q;
      bus.getbits       = getbits_q;
      bus.signbit       = signbit_q;
      bus.sc_found      = sc_found_q;
      bus.bit_count     = bit_count_q;
      bus.vld_en        = vld_en_q;
   end
endmodule

// File: tb/tb_getbits_param.sv
// tb/tb_getbits_param.sv - scoreboard bench for getbits_param
// A bit-level stream model predicts each window; the FIFO model answers read pulses.
module tb_getbits_param;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   getbits_param_if bus ();
   getbits_param dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [23:0] gb;
      logic        sb;
      logic [31:0] cnt;
      logic        sc;
   } exp_t;

   exp_t        sb_q[$];
   logic [63:0] fifo_q[$];
   logic [63:0] stream[$];
   int          abs_pos = 0;
   int          checks = 0;
   int          failures = 0;
   int          sc_count = 0;
   bit          req_seen = 1'b0;

   always @(negedge clk) begin
      bus.vid_in_rd_valid = 1'b0;
      if (req_seen && fifo_q.size() > 0) begin
         bus.vid_in          = fifo_q.pop_front();
         bus.vid_in_rd_valid = 1'b1;
      end
      req_seen = (bus.vid_in_rd_en === 1'b1);
   end

   always @(negedge clk) if (bus.sc_found === 1'b1) sc_count++;

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [24:0] model_win(input int pos);
      logic [24:0] r;
      logic [63:0] w;
      int p;
      r = '0;
      for (int i = 0; i < 25; i++) begin
         p = pos + i;
         if (p / 64 < stream.size()) begin
            w = stream[p / 64];
            r[24 - i] = w[63 - (p % 64)];
         end
      end
      return r;
   endfunction

   task automatic load(input logic [63:0] w);
      fifo_q.push_back(w);
      stream.push_back(w);
   endtask

   task automatic push_exp(input logic sc);
      exp_t e;
      logic [24:0] w;
      w     = model_win(abs_pos);
      e.gb  = w[24:1];
      e.sb  = w[0];
      e.cnt = 32'(abs_pos);
      e.sc  = sc;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      int n = 0;
      while (bus.getbits_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.getbits_valid !== 1'b1) chk({tag, "_valid_timeout"}, 64'(bus.getbits_valid), 64'd1);
      e = sb_q.pop_front();
      chk({tag, "_getbits"}, 64'(bus.getbits), 64'(e.gb));
      chk({tag, "_signbit"}, 64'(bus.signbit), 64'(e.sb));
      chk({tag, "_bit_count"}, 64'(bus.bit_count), 64'(e.cnt));
      chk({tag, "_sc_found"}, 64'(bus.sc_found), 64'(e.sc));
   endtask

   task automatic cmd(input int adv, input logic al, input logic sk);
      int n = 0;
      while (bus.getbits_valid !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (bus.getbits_valid !== 1'b1) chk("cmd_valid_timeout", 64'(bus.getbits_valid), 64'd1);
      bus.advance = 5'(adv);
      bus.align   = al;
      bus.seek_sc = sk;
      @(negedge clk);
      bus.advance = '0;
      bus.align   = 1'b0;
      bus.seek_sc = 1'b0;
   endtask

   task automatic do_adv(input int a, input string tag);
      cmd(a, 1'b0, 1'b0);
      abs_pos += (a > 24) ? 24 : a;
      push_exp(1'b0);
      pop_check(tag);
   endtask

   task automatic do_align(input string tag);
      cmd(0, 1'b1, 1'b0);
      abs_pos = (abs_pos & ~7) + 8;
      push_exp(1'b0);
      pop_check(tag);
   endtask

   task automatic do_seek(input string tag);
      logic [24:0] w;
      cmd(0, 1'b0, 1'b1);
      abs_pos = (abs_pos + 7) & ~7;
      for (int i = 0; i < 64; i++) begin
         w = model_win(abs_pos);
         if (w[24:1] == 24'h000001) break;
         abs_pos += 8;
      end
      push_exp(1'b1);
      pop_check(tag);
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      stream.delete();
      abs_pos = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_getbits"}, 64'(bus.getbits), 64'd0);
      chk({tag, "_signbit"}, 64'(bus.signbit), 64'd0);
      chk({tag, "_valid"}, 64'(bus.getbits_valid), 64'd0);
      chk({tag, "_rd_en"}, 64'(bus.vid_in_rd_en), 64'd0);
      chk({tag, "_sc_found"}, 64'(bus.sc_found), 64'd0);
      chk({tag, "_bit_count"}, 64'(bus.bit_count), 64'd0);
      chk({tag, "_vld_en"}, 64'(bus.vld_en), 64'd1);
   endtask

   initial begin
      logic exp_vld;
      int n;
      rst            = 1'b0;
      bus.clk_en     = 1'b1;
      bus.advance    = '0;
      bus.align      = 1'b0;
      bus.seek_sc    = 1'b0;
      bus.flush      = 1'b0;
      bus.wait_state = 1'b0;
      bus.stall      = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset("reset");

      load(64'h0123456789ABCDEF);
      load(64'hFEDCBA9876543210);
      load(64'h0011223344556677);
      rst = 1'b1;
      push_exp(1'b0);
      pop_check("first");
      do_adv(24, "adv24a");
      do_adv(24, "adv24b");
      do_adv(16, "adv16_refill");
      do_adv(31, "adv_sat");
      do_adv(3, "adv3");
      do_align("align");

      do_flush();
      load(64'hFF000001B3000000);
      load(64'h1122334455667788);
      push_exp(1'b0);
      pop_check("flush_fill");
      do_seek("seek");

      do_flush();
      load(64'hAAAAAAAAAAAAAAAA);
      load(64'h5555555555555555);
      push_exp(1'b0);
      pop_check("fill_nosc");
      fifo_q.push_back(64'h000001AA000001BB);
      cmd(0, 1'b0, 1'b1);
      n = 0;
      while (bus.vid_in_rd_en !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("seek_refill_rd_en", 64'(bus.vid_in_rd_en), 64'd1);
      do_flush();
      load(64'hC0C1C2C3C4C5C6C7);
      load(64'hD0D1D2D3D4D5D6D7);
      push_exp(1'b0);
      pop_check("flush_discard");
      chk("sc_count", 64'(sc_count), 64'd1);

      bus.stall = 1'b1;
      @(negedge clk);
      chk("stall_vld_en", 64'(bus.vld_en), 64'd0);
      chk("stall_valid", 64'(bus.getbits_valid), 64'd1);
      bus.stall = 1'b0;
      @(negedge clk);
      chk("unstall_vld_en", 64'(bus.vld_en), 64'd1);
      bus.wait_state = 1'b1;
      exp_vld = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_vld = ~exp_vld;
         chk("wait_toggle_vld_en", 64'(bus.vld_en), 64'(exp_vld));
      end
      bus.wait_state = 1'b0;
      @(negedge clk);

      bus.clk_en  = 1'b0;
      bus.advance = 5'd8;
      repeat (3) @(negedge clk);
      push_exp(1'b0);
      pop_check("clk_en_hold");
      bus.advance = '0;
      bus.clk_en  = 1'b1;

      load(64'hE0E1E2E3E4E5E6E7);
      do_adv(24, "pre_rst_a");
      do_adv(24, "pre_rst_b");
      cmd(24, 1'b0, 1'b0);
      n = 0;
      while (bus.vid_in_rd_en !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("refill_rd_en", 64'(bus.vid_in_rd_en), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk_reset("async_rst");
      repeat (2) @(negedge clk);
      chk_reset("rst_hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
